// File: rtl/vector_pkg.sv
// Shared vector-pipeline definitions: register-file geometry, opcode width
// and the VRR->VEXE payload carried by the register-read stage.
package vector_pkg;

  localparam int unsigned VLEN   = 128;
  localparam int unsigned NREG   = 32;
  localparam int unsigned RIDX_W = $clog2(NREG);
  localparam int unsigned OPW    = 8;

  typedef logic [RIDX_W-1:0] ridx_t;
  typedef logic [VLEN-1:0]   vreg_t;
  typedef logic [OPW-1:0]    vop_t;

  typedef struct packed {
    ridx_t vs1;
    ridx_t vs2;
    ridx_t vd;
    vop_t  op;
    logic  we;
    vreg_t dataa;
    vreg_t datab;
  } vrr_vexe_t;

  // Read-port value with the same-cycle writeback forwarded over the stored entry.
  function automatic vreg_t wb_bypass(input logic  we,
                                      input ridx_t waddr,
                                      input vreg_t wdata,
                                      input ridx_t raddr,
                                      input vreg_t stored);
    return (we && (waddr == raddr)) ? wdata : stored;
  endfunction

endpackage

// File: rtl/vector_regfile.sv
// Vector register file: NREG x VLEN, one write port, two combinational
// write-through read ports. Every entry clears on reset; register 0 is ordinary.
module vector_regfile
  import vector_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              we_i,
  input  logic [RIDX_W-1:0] waddr_i,
  input  logic [VLEN-1:0]   wdata_i,
  input  logic [RIDX_W-1:0] raddr_a_i,
  input  logic [RIDX_W-1:0] raddr_b_i,
  output logic [VLEN-1:0]   rdata_a_o,
  output logic [VLEN-1:0]   rdata_b_o
);

  vreg_t mem [NREG];

  // Storage: clear all entries on reset, otherwise commit the writeback.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Read ports: a write to the addressed entry this cycle wins over storage.
  always_comb begin
    rdata_a_o = wb_bypass(we_i, waddr_i, wdata_i, raddr_a_i, mem[raddr_a_i]);
    rdata_b_o = wb_bypass(we_i, waddr_i, wdata_i, raddr_b_i, mem[raddr_b_i]);
  end

endmodule

// File: rtl/vector_reg_read.sv
// Vector register-read stage: reads two operands from the vector register
// file and registers them, with the decoded fields, into the VRR->VEXE
// pipeline register under a valid/ready handshake with stall and flush.
module vector_reg_read
  import vector_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              dec_vrr_valid_i,
  output logic              dec_vrr_ready_o,
  input  logic [RIDX_W-1:0] dec_vrr_vs1_i,
  input  logic [RIDX_W-1:0] dec_vrr_vs2_i,
  input  logic [RIDX_W-1:0] dec_vrr_vd_i,
  input  logic [OPW-1:0]    dec_vrr_op_i,
  input  logic              dec_vrr_we_i,
  input  logic              wb_we_i,
  input  logic [RIDX_W-1:0] vexe_vwb_vd_i,
  input  logic [VLEN-1:0]   wb_vd_data_i,
  output logic              vrr_vexe_valid_o,
  input  logic              vexe_vrr_ready_i,
  output logic [RIDX_W-1:0] vrr_vexe_vs1_o,
  output logic [RIDX_W-1:0] vrr_vexe_vs2_o,
  output logic [RIDX_W-1:0] vrr_vexe_vd_o,
  output logic [OPW-1:0]    vrr_vexe_op_o,
  output logic              vrr_vexe_we_o,
  output logic [VLEN-1:0]   vrr_vexe_dataa_o,
  output logic [VLEN-1:0]   vrr_vexe_datab_o
);

  logic      out_valid_q;
  vrr_vexe_t out_q;
  vrr_vexe_t load_d;
  vreg_t     rd_a;
  vreg_t     rd_b;
  logic      load;
  logic      refresh_a;
  logic      refresh_b;

  vector_regfile u_regfile (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .we_i      (wb_we_i),
    .waddr_i   (vexe_vwb_vd_i),
    .wdata_i   (wb_vd_data_i),
    .raddr_a_i (dec_vrr_vs1_i),
    .raddr_b_i (dec_vrr_vs2_i),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  assign dec_vrr_ready_o = !out_valid_q || vexe_vrr_ready_i;
  assign load            = dec_vrr_valid_i && dec_vrr_ready_o && !flush_i;

  // Assemble the incoming payload and the held-operand refresh matches.
  always_comb begin
    load_d.vs1   = dec_vrr_vs1_i;
    load_d.vs2   = dec_vrr_vs2_i;
    load_d.vd    = dec_vrr_vd_i;
    load_d.op    = dec_vrr_op_i;
    load_d.we    = dec_vrr_we_i;
    load_d.dataa = rd_a;
    load_d.datab = rd_b;
    refresh_a    = wb_we_i && (vexe_vwb_vd_i == out_q.vs1);
    refresh_b    = wb_we_i && (vexe_vwb_vd_i == out_q.vs2);
  end

  // Pipeline register: flush > load > drain > refresh of a stalled operand.
  // A stalled instruction keeps tracking writebacks so it never leaves with
  // a stale operand once the register file has moved on.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_q       <= load_d;
    end else if (vexe_vrr_ready_i) begin
      out_valid_q <= 1'b0;
    end else if (out_valid_q) begin
      if (refresh_a) out_q.dataa <= wb_vd_data_i;
      if (refresh_b) out_q.datab <= wb_vd_data_i;
    end
  end

  assign vrr_vexe_valid_o = out_valid_q;
  assign vrr_vexe_vs1_o   = out_q.vs1;
  assign vrr_vexe_vs2_o   = out_q.vs2;
  assign vrr_vexe_vd_o    = out_q.vd;
  assign vrr_vexe_op_o    = out_q.op;
  assign vrr_vexe_we_o    = out_q.we;
  assign vrr_vexe_dataa_o = out_q.dataa;
  assign vrr_vexe_datab_o = out_q.datab;

endmodule

// File: doc/vector_reg_read.md
# vector_reg_read

Vector register-read stage (VRR): holds the 32-entry × 128-bit vector register file, reads two source operands per instruction and registers them into the VRR→VEXE pipeline register. It sits between vector decode and the execute-stage operand forwarder. Writeback from VWB enters here as the single register-file write port. A valid/ready handshake with both neighbours lets the stage stall and flush without losing or duplicating instructions.

## Interface
- VLEN, 128, vector register width in bits
- NREG, 32, number of vector registers (index width clog2(NREG) = 5)
- OPW, 8, opcode field width carried through to execute

- clk_i  in  1  clock, all state updates on rising edge
- rstn_i  in  1  reset; one clock, asynchronous, active-low
- flush_i  in  1  kill the instruction in the output register and the incoming one
- dec_vrr_valid_i  in  1  decode presents an instruction
- dec_vrr_ready_o  out  1  stage accepts the instruction this cycle
- dec_vrr_vs1_i / dec_vrr_vs2_i / dec_vrr_vd_i  in  5 each  source and destination indices
- dec_vrr_op_i  in  OPW  opcode
- dec_vrr_we_i  in  1  instruction writes vd
- wb_we_i  in  1  writeback write enable
- vexe_vwb_vd_i  in  5  writeback destination index
- wb_vd_data_i  in  VLEN  writeback data
- vrr_vexe_valid_o  out  1  output register holds a live instruction
- vexe_vrr_ready_i  in  1  execute consumes the output this cycle
- vrr_vexe_vs1_o / vrr_vexe_vs2_o / vrr_vexe_vd_o  out  5 each  registered indices
- vrr_vexe_op_o  out  OPW  registered opcode
- vrr_vexe_we_o  out  1  registered write flag
- vrr_vexe_dataa_o / vrr_vexe_datab_o  out  VLEN  registered operands

## Operation
- Register file: NREG × VLEN entries, one write port (wb_we_i, vexe_vwb_vd_i, wb_vd_data_i), two combinational read ports (vs1, vs2). Register 0 is an ordinary register.
- Write-through read: if wb_we_i and vexe_vwb_vd_i equals a read index in the same cycle, that read returns wb_vd_data_i, not the stale entry.
- dec_vrr_ready_o = !vrr_vexe_valid_o || vexe_vrr_ready_i. This path is combinational.
- Load: when dec_vrr_valid_i && dec_vrr_ready_o && !flush_i, the output register captures indices, op, we and both read-port values. vrr_vexe_valid_o is set.
- Drain: when vexe_vrr_ready_i && vrr_vexe_valid_o and there is no load, vrr_vexe_valid_o clears.
- Hold-refresh: while valid and not consumed, a writeback with wb_we_i && vexe_vwb_vd_i == held vs1 replaces dataa with wb_vd_data_i. The same rule applies independently to vs2 and datab, and both update if both match.
- Flush: flush_i clears vrr_vexe_valid_o next edge. It has priority over load, drain and refresh. Any incoming instruction is dropped. Register-file writes still occur during flush.

## Timing
- Reset (async on rstn_i low): all register-file entries are 0. vrr_vexe_valid_o = 0. All vrr_vexe_* data, index, op and we outputs are 0. dec_vrr_ready_o is therefore 1.
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1.
- Full throughput: one instruction per cycle when vexe_vrr_ready_i is held high.
- A write in cycle N is visible to a read in cycle N via bypass, and is stored for cycle N+1 onward.
- Simultaneous consume and load in the same cycle: the new instruction replaces the old. valid stays 1.
- Reset asserted mid-stall: the held instruction is discarded and the register file is cleared.

## Structure
- Shared package vector_pkg: VLEN, NREG, register-index width, OPW, plus the VRR→VEXE payload struct (vs1, vs2, vd, op, we, dataa, datab). The execute stage and forwarder import the same package.
- Sub-module vector_regfile: storage, reset, and write-through read ports. The top level holds the pipeline register, handshake, refresh and flush logic.

## Test plan
- Reset, then write v3 = 0xAAAA…AA (wb_we_i=1). Next cycle issue vs1=3, vs2=0 -> one cycle later valid=1, dataa=0xAA…AA, datab=0.
- Same-cycle hazard: issue vs1=5 while writing v5 = 0x1234 -> dataa=0x1234 next cycle.
- Stall refresh: hold vexe_vrr_ready_i=0 with valid instruction vs2=7, then write v7 = 0xBEEF -> datab becomes 0xBEEF and dec_vrr_ready_o=0 throughout. Release ready -> consumed once, with no duplicate.
- Back-to-back: 8 instructions with ready high every cycle -> 8 consecutive valid outputs in order, and dec_vrr_ready_o constantly 1.
- Flush during stall with dec_vrr_valid_i=1 -> next cycle valid=0, and the incoming instruction never appears. A write asserted in the flush cycle still lands in the register file.
- Assert rstn_i low mid-stream (async, between edges) -> outputs go to 0 immediately, and a subsequent read of every register returns 0.
